accum_seq_ctrl: RTL and testbench

//  Job sequencer for the accumulator stage. Accepts a start plus a sample count, consumes

---
 rtl/accum_seq_ctrl_pkg.sv | 16 +
 rtl/accum_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_accum_seq_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/accum_seq_ctrl_pkg.sv
// Shared definitions for the accumulator job sequencer: default widths,
// clear value and the FSM state encoding.
package accum_seq_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int LEN_WIDTH_DEF  = 8;
  localparam int ACCUM_INIT_DEF = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/accum_seq_ctrl.sv
// Job sequencer for the accumulator stage. Counts cfg_len samples into the
// external accumulator (the adder lives here), then presents the final sum
// once on the result port.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both 1. The producer keeps valid and data stable until that edge; ready may
// depend on state only. in_* is the sample stream (this block is the sink),
// res_* is the result stream (this block is the source).
module accum_seq_ctrl
  import accum_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int ACCUM_INIT = ACCUM_INIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  start,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  acc_stg_en,
  output logic [DATA_WIDTH-1:0] acc_data_in,
  input  logic [DATA_WIDTH-1:0] acc_data_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ovf,
  output state_t                dbg_state
);

  localparam logic [DATA_WIDTH-1:0] INIT_VAL = DATA_WIDTH'(ACCUM_INIT);

  state_t                state_q;
  state_t                state_nxt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic                  accept;
  logic                  last_accept;
  logic [DATA_WIDTH:0]   sum;

  assign dbg_state = state_q;

  // State register; reset aborts any job in flight without a result.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state, stream controls and accumulator drive, all decoded from state.
  always_comb begin
    state_nxt   = state_q;
    busy        = 1'b1;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    acc_stg_en  = 1'b0;
    acc_data_in = '0;
    accept      = 1'b0;
    last_accept = 1'b0;
    sum         = {1'b0, acc_data_out};
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (cfg_len != '0) ? ST_RUN : ST_FLUSH;
        end
      end
      ST_RUN: begin
        // stg_en stays high on stall cycles so the running sum is kept
        in_ready    = 1'b1;
        acc_stg_en  = 1'b1;
        accept      = in_valid;
        sum         = {1'b0, acc_data_out} + {1'b0, (accept ? in_data : '0)};
        acc_data_in = sum[DATA_WIDTH-1:0];
        last_accept = accept && (count_q == len_q - 1'b1);
        if (last_accept) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // hold the sum one more cycle while it is copied to res_data
        acc_stg_en  = 1'b1;
        acc_data_in = acc_data_out;
        state_nxt   = ST_DONE;
      end
      ST_DONE: begin
        // stg_en low clears the accumulator for the next job
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Job bookkeeping: latched length, sample count, sticky carry and result.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      len_q    <= '0;
      count_q  <= '0;
      res_data <= '0;
      res_ovf  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q   <= cfg_len;
            count_q <= '0;
            res_ovf <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            count_q <= count_q + 1'b1;
            res_ovf <= res_ovf | sum[DATA_WIDTH];
          end
        end
        ST_FLUSH: begin
          // an empty job never enabled the accumulator, so its result is the clear value
          res_data <= (len_q == '0) ? INIT_VAL : acc_data_out;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Bench for accum_seq_ctrl with a behavioural accumulator beside it.
// Drivers push the hand-computed result of each job into exp_q; a monitor
// pops and compares whenever a result handshake occurs.
module tb_accum_seq_ctrl;
  import accum_seq_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam logic [DW-1:0] INIT = '0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] cfg_len;
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          acc_stg_en;
  logic [DW-1:0] acc_data_in;
  logic [DW-1:0] acc_data_out;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_ovf;
  state_t        dbg_state;

  logic [DW:0]   exp_q[$];
  int            n_vec  = 0;
  int            n_fail = 0;

  accum_seq_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACCUM_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_stg_en(acc_stg_en), .acc_data_in(acc_data_in), .acc_data_out(acc_data_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // accumulator neighbour: clears when stg_en is low, loads data_in otherwise
  always @(posedge clk) begin
    if (rst_n || !acc_stg_en) acc_data_out <= INIT;
    else                      acc_data_out <= acc_data_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(res_valid), 32'd0);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("res_data", 32'(res_data), 32'(e[DW-1:0]));
        check("res_ovf", 32'(res_ovf), 32'(e[DW]));
      end
    end
  end

  // driver tasks
  task automatic start_job(input int len, input logic ovf, input logic [DW-1:0] sum);
    cfg_len = LW'(len);
    start = 1'b1;
    exp_q.push_back({ovf, sum});
    tick();
    start = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input int gap);
    int waited;
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check("stall_stg_en", 32'(acc_stg_en), 32'd1);
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      tick();
      @(negedge clk);
      waited++;
    end
    check("in_ready", 32'(in_ready), 32'd1);
    check("run_stg_en", 32'(acc_stg_en), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // called right after the last accept (or a len=0 start): FLUSH, then DONE
  task automatic expect_latency();
    @(negedge clk);
    check("flush_no_valid", 32'(res_valid), 32'd0);
    check("flush_no_ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    check("res_latency", 32'(res_valid), 32'd1);
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_stg_en", 32'(acc_stg_en), 32'd0);
    check("rst_data_in", 32'(acc_data_in), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_ovf", 32'(res_ovf), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; cfg_len = '0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
    repeat (2) tick();
    check_reset_outputs();
    tick();
    rst_n = 1'b0;
    tick();

    // len=4, back-to-back 1..4 -> 10
    start_job(4, 1'b0, 16'd10);
    send_sample(16'd1, 0);
    send_sample(16'd2, 0);
    send_sample(16'd3, 0);
    send_sample(16'd4, 0);
    expect_latency();
    tick();
    expect_idle("idle_after_job1");

    // len=3 with two stall cycles between samples -> 21
    start_job(3, 1'b0, 16'd21);
    send_sample(16'd5, 0);
    send_sample(16'd7, 2);
    send_sample(16'd9, 2);
    expect_latency();
    tick();

    // carry out: 0xFFF0 + 0x0020 -> 0x0010 with ovf
    start_job(2, 1'b1, 16'h0010);
    send_sample(16'hFFF0, 0);
    send_sample(16'h0020, 0);
    expect_latency();
    tick();
    // following job starts with ovf cleared
    start_job(1, 1'b0, 16'd3);
    send_sample(16'd3, 0);
    expect_latency();
    tick();

    // len=0: no samples taken even with in_valid high
    in_valid = 1'b1;
    in_data  = 16'h1234;
    start_job(0, 1'b0, INIT);
    expect_latency();
    check("len0_no_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;

    // result held for 5 cycles with start asserted during DONE
    res_ready = 1'b0;
    start_job(2, 1'b0, 16'd300);
    send_sample(16'd100, 0);
    send_sample(16'd200, 0);
    expect_latency();
    start = 1'b1;
    cfg_len = 8'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'd300);
    end
    res_ready = 1'b1;
    tick();
    start = 1'b0;
    expect_idle("start_in_done_ignored");

    // reset mid-job, then a fresh len=1 job
    start_job(4, 1'b0, 16'd0);
    send_sample(16'd11, 0);
    send_sample(16'd22, 0);
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    check_reset_outputs();
    rst_n = 1'b0;
    tick();
    start_job(1, 1'b0, 16'd6);
    send_sample(16'd6, 0);
    expect_latency();
    tick();

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
